// File: rtl/dds_pkg.sv
// Shared types and elaboration-time helpers for the DDS sine generator.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package dds_pkg;

    // Quadrant of the phase word (top two bits).
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Mid-scale code of the offset-binary output.
    function automatic int mid_val(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    // Peak magnitude; equal to mid-scale so MID +/- MAXM spans 0..2*MID.
    function automatic int maxm_val(input int out_w);
        return mid_val(out_w);
    endfunction

    // Quarter-wave entry i, sampled at the half step so that mirroring
    // the address (~idx) lands exactly on the symmetric point.
    function automatic int lut_entry(input int i, input int lut_aw, input int out_w);
        real ang;
        real v;
        ang = 3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(1 << lut_aw);
        v   = real'(maxm_val(out_w)) * $sin(ang);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/quarter_sine_lut.sv
// Quarter-wave sine magnitude table with a registered read port.
// Latency: 1 cycle from addr_i to mag_o.
// Backpressure: en_i low holds mag_o so a stalled pipeline keeps its sample.
module quarter_sine_lut
    import dds_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [LUT_AW-1:0] addr_i,
    output logic [OUT_W-1:0]  mag_o
);

    logic [OUT_W-1:0] rom [2**LUT_AW];
    logic [OUT_W-1:0] mag_q;

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        assign rom[i] = OUT_W'(lut_entry(i, LUT_AW, OUT_W));
    end

    // Registered table read, held while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mag_q <= rom[addr_i];
        end
    end

    assign mag_o = mag_q;

endmodule

// File: rtl/dds_sine_gen.sv
// Multi-channel DDS sine generator: per-channel accumulators, shared quarter-wave LUT.
// Latency: tick in cycle T -> channel 0 on out_valid in T+4, then one channel per cycle.
// Backpressure: out_valid && !out_ready freezes all stages and the issue counter.
module dds_sine_gen
    import dds_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_tick,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic               cfg_phase_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    out_ch,
    output logic [OUT_W-1:0]   out_data,
    output logic               busy,
    output logic               overrun,
    input  logic               overrun_clr
);

    localparam logic [OUT_W-1:0] MID     = OUT_W'(mid_val(OUT_W));
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    // Per-channel configuration and phase state.
    logic [PHASE_W-1:0] acc_q  [NUM_CH];
    logic [PHASE_W-1:0] ftw_q  [NUM_CH];
    logic [PHASE_W-1:0] poff_q [NUM_CH];
    logic [PHASE_W-1:0] snap_q [NUM_CH];

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              issue;

    // Pipeline registers: stage 1 = fold, stage 2 = LUT read, stage 3 = output.
    logic              s1_vld_q;
    logic [LUT_AW-1:0] s1_addr_q;
    quad_e             s1_quad_q;
    logic [CH_W-1:0]   s1_ch_q;
    logic              s2_vld_q;
    quad_e             s2_quad_q;
    logic [CH_W-1:0]   s2_ch_q;
    logic              out_valid_q;
    logic [OUT_W-1:0]  out_data_q;
    logic [CH_W-1:0]   out_ch_q;
    logic              overrun_q;

    logic              stall;
    logic              adv;
    logic              frame_start;
    logic [LUT_AW+1:0] phase_top;
    quad_e             quad;
    logic [LUT_AW-1:0] idx;
    logic [LUT_AW-1:0] fold_addr;
    logic [OUT_W-1:0]  mag;
    logic [OUT_W-1:0]  sample;

    assign stall       = out_valid_q && !out_ready;
    assign adv         = !stall;
    assign frame_start = sample_tick && (state_q == IDLE);

    // Only the quadrant and LUT index bits of the phase matter; the rest truncate.
    assign phase_top = snap_q[ch_q][PHASE_W-1 -: LUT_AW+2];
    assign quad      = quad_e'(phase_top[LUT_AW+1 -: 2]);
    assign idx       = phase_top[LUT_AW-1:0];
    assign fold_addr = (quad == Q1 || quad == Q3) ? ~idx : idx;

    // Accumulators advance on every tick; a config write with clear overrides that advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c]  <= '0;
                ftw_q[c]  <= '0;
                poff_q[c] <= '0;
                snap_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sample_tick) begin
                    acc_q[c] <= acc_q[c] + ftw_q[c];
                end
                if (cfg_we && (cfg_ch == CH_W'(c))) begin
                    ftw_q[c]  <= cfg_ftw;
                    poff_q[c] <= cfg_poff;
                    if (cfg_phase_clr) begin
                        acc_q[c] <= '0;
                    end
                end
                if (frame_start) begin
                    snap_q[c] <= acc_q[c] + poff_q[c];
                end
            end
        end
    end

    // Frame sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Frame sequencer: issue channels in order, then wait for the pipeline to empty.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = ISSUE;
                    ch_d    = '0;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (adv) begin
                    ch_d = ch_q + 1'b1;
                    if (ch_q == LAST_CH) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!s1_vld_q && !s2_vld_q && (!out_valid_q || out_ready)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    quarter_sine_lut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_lut (
        .clk    (clk),
        .en_i   (adv),
        .addr_i (s1_addr_q),
        .mag_o  (mag)
    );

    // Lower half of the period subtracts the magnitude from mid-scale.
    assign sample = (s2_quad_q == Q2 || s2_quad_q == Q3) ? (MID - mag) : (MID + mag);

    // Three-stage pipeline, advanced as a whole whenever the output is not stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_quad_q   <= Q0;
            s1_ch_q     <= '0;
            s2_vld_q    <= 1'b0;
            s2_quad_q   <= Q0;
            s2_ch_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (adv) begin
            s1_vld_q    <= issue;
            s1_addr_q   <= fold_addr;
            s1_quad_q   <= quad;
            s1_ch_q     <= ch_q;
            s2_vld_q    <= s1_vld_q;
            s2_quad_q   <= s1_quad_q;
            s2_ch_q     <= s1_ch_q;
            out_valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_data_q <= sample;
                out_ch_q   <= s2_ch_q;
            end
        end
    end

    // Sticky overrun: a tick that cannot start a frame; setting beats clearing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (sample_tick && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dds_sine_gen.sv
// Directed self-checking bench for dds_sine_gen (4 channels, 16-bit phase, 8-bit out).
// Latency: checks channel 0 at T+4 after the tick and in-order channel delivery.
// Backpressure: exercises stalls, overrun and reset while stalled mid-frame.
module tb_dds_sine_gen;

    localparam int NUM_CH  = 4;
    localparam int PHASE_W = 16;
    localparam int LUT_AW  = 8;
    localparam int OUT_W   = 8;
    localparam int CH_W    = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_tick = 1'b0;
    logic               cfg_we = 1'b0;
    logic [CH_W-1:0]    cfg_ch = '0;
    logic [PHASE_W-1:0] cfg_ftw = '0;
    logic [PHASE_W-1:0] cfg_poff = '0;
    logic               cfg_phase_clr = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [CH_W-1:0]    out_ch;
    logic [OUT_W-1:0]   out_data;
    logic               busy;
    logic               overrun;
    logic               overrun_clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int mon_ch[$];
    int mon_dat[$];

    int s0[1024];
    int s1[1024];
    int n0, n1, mn, mx, bad_sym, bad_per, bad_half, c_v, d_v;
    int pat_poff[4] = '{32'h4000, 32'h8000, 32'hC000, 32'h3FC0};
    int pat_exp[4]  = '{254, 127, 0, 254};

    always #5 clk = ~clk;

    dds_sine_gen #(
        .NUM_CH  (NUM_CH),
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .OUT_W   (OUT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_ftw       (cfg_ftw),
        .cfg_poff      (cfg_poff),
        .cfg_phase_clr (cfg_phase_clr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ch        (out_ch),
        .out_data      (out_data),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    // Record every accepted sample; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            mon_ch.push_back(int'(out_ch));
            mon_dat.push_back(int'(out_data));
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input int ch, input int ftw, input int poff, input bit clr);
        step();
        cfg_we        = 1'b1;
        cfg_ch        = CH_W'(ch);
        cfg_ftw       = PHASE_W'(ftw);
        cfg_poff      = PHASE_W'(poff);
        cfg_phase_clr = clr;
        step();
        cfg_we        = 1'b0;
        cfg_phase_clr = 1'b0;
    endtask

    task automatic tick();
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, int'(busy), 0);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, int'(out_valid), 1);
    endtask

    task automatic check_frame(input string tag, input int e0, input int e1,
                               input int e2, input int e3);
        int k = 0;
        int exp[4];
        exp = '{e0, e1, e2, e3};
        while (mon_ch.size() < 4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_count"}, mon_ch.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (mon_ch.size() > 0) begin
                check_eq({tag, "_ch"}, mon_ch.pop_front(), i);
                check_eq({tag, "_data"}, mon_dat.pop_front(), exp[i]);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_valid"}, int'(out_valid), 0);
        check_eq({tag, "_data"}, int'(out_data), 0);
        check_eq({tag, "_ch"}, int'(out_ch), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // Single phase points on channel 0, plus exact first-sample latency
        cfg_wr(0, 0, 0, 1'b1);
        tick();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("lat_T+3_valid", int'(out_valid), 0);
        @(negedge clk);
        check_eq("lat_T+4_valid", int'(out_valid), 1);
        check_eq("lat_T+4_ch", int'(out_ch), 0);
        check_eq("lat_T+4_data", int'(out_data), 127);
        check_frame("poff0000", 127, 127, 127, 127);
        wait_idle("idle_poff0000");
        for (int p = 0; p < 4; p++) begin
            cfg_wr(0, 0, pat_poff[p], 1'b0);
            tick();
            check_frame($sformatf("poff%04h", pat_poff[p]), pat_exp[p], 127, 127, 127);
            wait_idle("idle_poff");
        end

        // Four channels at the four quadrant starts
        cfg_wr(0, 0, 16'h0000, 1'b0);
        cfg_wr(1, 0, 16'h4000, 1'b0);
        cfg_wr(2, 0, 16'h8000, 1'b0);
        cfg_wr(3, 0, 16'hC000, 1'b0);
        tick();
        check_frame("quad4", 127, 254, 127, 0);
        wait_idle("idle_quad4");

        // Backpressure: hold channel 0 for five cycles, then drain
        step();
        out_ready = 1'b0;
        tick();
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_hold_valid", int'(out_valid), 1);
            check_eq("stall_hold_ch", int'(out_ch), 0);
            check_eq("stall_hold_data", int'(out_data), 127);
            check_eq("stall_hold_busy", int'(busy), 1);
        end
        step();
        out_ready = 1'b1;
        check_frame("stall", 127, 254, 127, 0);
        wait_idle("idle_stall");
        repeat (5) @(negedge clk);
        check_eq("stall_no_dup", mon_ch.size(), 0);

        // Overrun: second tick two cycles after the first while stalled
        cfg_wr(0, 16'h1000, 0, 1'b1);
        step();
        out_ready   = 1'b0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        @(negedge clk);
        check_eq("overrun_set", int'(overrun), 1);
        step();
        out_ready = 1'b1;
        check_frame("ovr_frame", 127, 254, 127, 0);
        wait_idle("idle_ovr");
        repeat (10) @(negedge clk);
        check_eq("ovr_no_extra", mon_ch.size(), 0);
        check_eq("overrun_sticky", int'(overrun), 1);
        step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check_eq("overrun_clr", int'(overrun), 0);
        tick();
        check_frame("ovr_next", 217, 254, 127, 0);
        wait_idle("idle_ovr_next");

        // Periodic waveform: ch0 ftw 0x100, ch1 ftw 0x200, 1024 frames
        cfg_wr(0, 16'h0100, 0, 1'b1);
        cfg_wr(1, 16'h0200, 0, 1'b1);
        for (int k = 0; k < 1024; k++) begin
            tick();
            wait_idle("idle_period");
        end
        repeat (2) @(negedge clk);
        check_eq("period_count", mon_ch.size(), 4096);
        n0 = 0;
        n1 = 0;
        while (mon_ch.size() > 0) begin
            c_v = mon_ch.pop_front();
            d_v = mon_dat.pop_front();
            if (c_v == 0 && n0 < 1024) begin
                s0[n0] = d_v;
                n0++;
            end else if (c_v == 1 && n1 < 1024) begin
                s1[n1] = d_v;
                n1++;
            end
        end
        check_eq("period_n0", n0, 1024);
        check_eq("period_n1", n1, 1024);
        mn = 999;
        mx = -1;
        bad_sym = 0;
        bad_per = 0;
        bad_half = 0;
        for (int k = 0; k < 1024; k++) begin
            if (s0[k] < mn) mn = s0[k];
            if (s0[k] > mx) mx = s0[k];
            if (k < 896 && (s0[k] + s0[k+128] != 254)) bad_sym++;
            if (k < 768 && (s0[k] != s0[k+256])) bad_per++;
            if (k < 896 && (s1[k] != s1[k+128])) bad_half++;
            if (k < 512 && (s1[k] != s0[2*k])) bad_half++;
        end
        check_eq("wave_min", mn, 0);
        check_eq("wave_max", mx, 254);
        check_eq("wave_s0_0", s0[0], 127);
        check_eq("wave_s0_32", s0[32], 217);
        check_eq("wave_s0_64", s0[64], 254);
        check_eq("wave_s0_128", s0[128], 127);
        check_eq("wave_s0_192", s0[192], 0);
        check_eq("wave_symmetry_errs", bad_sym, 0);
        check_eq("wave_period_errs", bad_per, 0);
        check_eq("wave_half_period_errs", bad_half, 0);

        // Reset asserted while stalled in ISSUE with out_valid high
        step();
        out_ready = 1'b0;
        tick();
        wait_valid("rst_mid_valid");
        check_eq("rst_mid_busy", int'(busy), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        check_frame("post_rst", 127, 127, 127, 127);
        wait_idle("idle_post_rst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dds_sine_gen.md
Name: dds_sine_gen

Overview:
- Multi-channel direct-digital-synthesis sine generator.
- Per-channel phase accumulators feed one shared, registered quarter-wave magnitude LUT; quadrant folding rebuilds the full period.
- Produces offset-binary samples over a valid/ready stream.
- Successor to the fixed 8-bit quarter-wave table; feeds the DAC/PWM output stage.

Parameters:
- NUM_CH, 2, number of independent channels (1..16)
- PHASE_W, 16, accumulator / tuning word / phase offset width
- LUT_AW, 8, quarter-wave LUT address width (2^LUT_AW entries)
- OUT_W, 8, output sample width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle strobe: advance all accumulators, start one output frame
- cfg_we  in  1  config write strobe
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel addressed by cfg_we
- cfg_ftw  in  PHASE_W  frequency tuning word written on cfg_we
- cfg_poff  in  PHASE_W  phase offset written on cfg_we
- cfg_phase_clr  in  1  with cfg_we: also zero that channel's accumulator
- out_valid  out  1  sample available
- out_ready  in  1  downstream accepts sample
- out_ch  out  $clog2(NUM_CH) (min 1)  channel of current sample
- out_data  out  OUT_W  offset-binary sine sample
- busy  out  1  frame in progress
- overrun  out  1  sticky: sample_tick arrived while busy
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async): all outputs 0; accumulators, FTW and POFF registers 0; FSM in IDLE.
- MID = 2^(OUT_W-1)-1. MAXM = MID.
- LUT entry i = round(MAXM*sin(pi/2*(i+0.5)/2^LUT_AW)), computed at elaboration. Half-step offset makes mirroring exact.
- Phase decode: q = phase[PHASE_W-1:PHASE_W-2]; idx = next LUT_AW bits; lower bits truncated.
  - q=1 or q=3: addr = ~idx; otherwise addr = idx.
  - q=0 or q=1: out = MID + mag; q=2 or q=3: out = MID - mag.
  - Output range is 0..2*MID; no overflow.
- Accumulators: on sample_tick, acc[c] <= acc[c] + ftw[c], modulo 2^PHASE_W, for every channel, even while busy.
- Config write:
  - On the write cycle, ftw/poff take the new value from the next cycle.
  - A tick in the same cycle uses the old FTW.
  - cfg_phase_clr with a tick in the same cycle on that channel: clear wins, acc = 0.
- Frame start:
  - sample_tick while IDLE: snap[c] <= acc[c] + poff[c] (pre-advance acc) for all c; FSM to ISSUE with ch = 0.
  - sample_tick while not IDLE: frame ignored, accumulators still advance, overrun <= 1.
  - overrun_clr and overrun set in the same cycle: set wins.
- FSM states:
  - IDLE -> ISSUE on tick.
  - ISSUE: fold snap[ch] into registered addr/q, ch++. After the last channel -> DRAIN.
  - DRAIN: wait until pipeline empty and final sample accepted -> IDLE.
- busy = (state != IDLE).
- Pipeline:
  - Stage 1: fold register.
  - Stage 2: LUT registered read.
  - Stage 3: combine into out_data / out_ch, out_valid = 1.
- Latency:
  - Tick at cycle T -> channel 0 at out_valid in cycle T+4.
  - Then one channel per cycle while out_ready = 1.
  - Channels always emitted in order 0..NUM_CH-1.
- Handshake:
  - Transfer when out_valid && out_ready.
  - out_valid && !out_ready stalls every stage and the ISSUE counter.
  - out_data / out_ch hold stable while stalled.
  - out_valid never drops without a transfer.
- out_valid deasserts the cycle after the last transfer if nothing follows.

Decomposition:
- Package dds_pkg: quadrant enum (Q0..Q3), FSM state enum (IDLE, ISSUE, DRAIN), MID/MAXM constant functions, LUT-content constant function.
- Sub-module quarter_sine_lut (params LUT_AW, OUT_W): clk, addr -> registered mag, contents from the package function.

Test Plan:
- Defaults, reset, then poff0 = 0x0000 / 0x4000 / 0x8000 / 0xC000 with ftw = 0, one tick per setting -> ch0 out_data 127, 254, 127, 0 at T+4. Mid-quadrant check: poff = 0x3FC0 -> 254.
- ch0 ftw = 0x0100, 1024 ticks, out_ready = 1 -> 4 full periods, waveform symmetric, min 0, max 254. Period of ch1 with ftw = 0x0200 is exactly half.
- NUM_CH = 4, all ftw = 0, poff = {0, 0x4000, 0x8000, 0xC000}, one tick -> four consecutive samples, out_ch 0,1,2,3, data 127, 254, 127, 0.
- out_ready low for 5 cycles after first out_valid -> out_data/out_ch held, no sample lost or duplicated, busy stays high until last transfer.
- Second tick 2 cycles after first (NUM_CH = 4, ready low) -> overrun = 1, no extra frame, next frame's phases reflect two accumulator advances. overrun_clr -> 0.
- Assert reset during ISSUE with out_valid = 1 -> all outputs 0 immediately; next tick after release restarts from acc = 0 with poff = 0.
